// File: rtl/mem_io_bridge_pkg.sv
// Shared constants for the memory/IO bridge: IO addresses, read-source and FSM encodings.
package mem_io_bridge_pkg;

  localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_CNT_ADDR  = 32'h0003_0004;

  typedef enum logic [1:0] {
    SRC_RAM = 2'd0,
    SRC_RX  = 2'd1,
    SRC_CNT = 2'd2
  } rd_src_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_SEND_NUL = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_io_bridge_io_tx_fifo.sv
// Power-of-two circular FIFO buffering UART transmit bytes.
module io_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU-side bridge: RAM pass-through, UART RX/TX byte ports, cycle counter and an end-of-program drain FSM.
//   state       | meaning
//   ST_RUN      | normal operation, IO writes accepted
//   ST_DRAIN    | stop requested, waiting for the TX FIFO to empty
//   ST_SEND_NUL | FIFO empty, emit a single 0x00 terminator when UART can take it
//   ST_DONE     | terminator sent, program_finish held until reset
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_full,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_empty,
  output logic        uart_rx_pop,
  output logic        program_finish
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] BUF_FULL_CNT = CW'(TX_DEPTH - 1);

  state_e        state_q, state_d;
  rd_src_e       src_q, src_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   snap_q, snap_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rd_vld_q, rd_vld_d;
  logic          overflow_q, overflow_d;

  logic          io_sel, rd_rx, rd_cnt, wr_uart, wr_cnt;
  logic          push_req, fifo_push, fifo_pop, nul_send;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  assign io_sel  = is_io(cpu_a);
  assign rd_rx   = ~cpu_wr & (cpu_a == IO_UART_ADDR);
  assign rd_cnt  = ~cpu_wr & (cpu_a[31:2] == IO_CNT_ADDR[31:2]);
  assign wr_uart = cpu_wr & (cpu_a == IO_UART_ADDR) & (state_q == ST_RUN);
  assign wr_cnt  = cpu_wr & (cpu_a == IO_CNT_ADDR) & (state_q == ST_RUN);

  assign ram_a   = cpu_a[16:0];
  assign ram_din = cpu_dout;
  assign ram_wr  = cpu_wr & rdy_in & ~io_sel;

  assign push_req  = wr_uart & (cpu_dout != 8'h00) & rdy_in;
  assign fifo_push = push_req & ~rst_in;
  assign fifo_pop  = rdy_in & ~rst_in & ~fifo_empty & ~uart_tx_full;

  // Pulses are gated by reset so a reset mid-transfer never emits a byte.
  assign uart_tx_valid  = fifo_pop | (nul_send & ~rst_in);
  assign uart_tx_data   = nul_send ? 8'h00 : fifo_head;
  assign uart_rx_pop    = rd_rx & ~uart_rx_empty & rdy_in & ~rst_in;
  assign io_buffer_full = (fifo_count >= BUF_FULL_CNT);
  assign program_finish = (state_q == ST_DONE);

  io_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .W     (8)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (cpu_dout),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    sel_d      = sel_q;
    rx_byte_d  = rx_byte_q;
    rd_vld_d   = rd_vld_q;
    overflow_d = overflow_q;
    nul_send   = 1'b0;
    if (rdy_in) begin
      cnt_d    = cnt_q + 32'd1;
      rd_vld_d = 1'b1;
      src_d    = SRC_RAM;
      if (rd_rx) begin
        src_d     = SRC_RX;
        rx_byte_d = uart_rx_empty ? 8'h00 : uart_rx_data;
      end
      // Snapshot on the low byte so the following byte reads stay coherent.
      if (rd_cnt) begin
        src_d = SRC_CNT;
        sel_d = cpu_a[1:0];
        if (cpu_a[1:0] == 2'b00) snap_d = cnt_q;
      end
      if (push_req & fifo_full) overflow_d = 1'b1;
      case (state_q)
        ST_RUN:      if (wr_cnt) state_d = ST_DRAIN;
        ST_DRAIN:    if (fifo_empty) state_d = ST_SEND_NUL;
        ST_SEND_NUL: if (!uart_tx_full) begin
                       nul_send = 1'b1;
                       state_d  = ST_DONE;
                     end
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cpu_din = 8'h00;
    if (rd_vld_q) begin
      case (src_q)
        SRC_RX:  cpu_din = rx_byte_q;
        SRC_CNT: cpu_din = snap_q[{sel_q, 3'b000} +: 8];
        default: cpu_din = ram_dout;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_RUN;
      src_q      <= SRC_RAM;
      cnt_q      <= '0;
      snap_q     <= '0;
      sel_q      <= '0;
      rx_byte_q  <= '0;
      rd_vld_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      sel_q      <= sel_d;
      rx_byte_q  <= rx_byte_d;
      rd_vld_q   <= rd_vld_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 8, giving UART transmit FIFO entries (power of two, at least 4).
REQ-002 SHALL have port clk_in, input, 1, the single clock; reset is synchronous and active-high.
REQ-003 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rdy_in, input, 1; when low, all state is frozen and ram_wr is forced to 0.
REQ-005 SHALL have port cpu_a, input, 32, CPU address bus.
REQ-006 SHALL have port cpu_wr, input, 1, CPU write strobe (1 = write).
REQ-007 SHALL have port cpu_dout, input, 8, CPU write byte.
REQ-008 SHALL have port cpu_din, output, 8, read byte returned to the CPU.
REQ-009 SHALL have port io_buffer_full, output, 1, TX backpressure to the CPU.
REQ-010 SHALL have ports ram_a (output, 17), ram_wr (output, 1), ram_din (output, 8) and ram_dout (input, 8); RAM read latency is 1 cycle.
REQ-011 SHALL have ports uart_tx_data (output, 8), uart_tx_valid (output, 1) and uart_tx_full (input, 1).
REQ-012 SHALL have ports uart_rx_data (input, 8), uart_rx_empty (input, 1) and uart_rx_pop (output, 1).
REQ-013 SHALL have port program_finish, output, 1, sticky stop indication.

Function
REQ-014 SHALL treat cpu_a[17:16]==2'b11 as IO and all other addresses as RAM; RAM accesses pass combinationally through ram_a=cpu_a[16:0], ram_din=cpu_dout, ram_wr=cpu_wr&rdy_in&~io.
REQ-015 SHALL register a 2-bit read source (RAM, RX, CNT) each enabled cycle; cpu_din in cycle N+1 SHALL be ram_dout, the latched RX byte or the selected counter byte for the read issued in cycle N.
REQ-016 SHALL maintain a 32-bit cycle counter, cleared by reset, incremented each cycle rdy_in is high, wrapping at 2^32.
REQ-017 SHALL snapshot the counter on a read of 0x30004 and return snapshot bytes for 0x30004..0x30007 (little-endian), so a 4-byte read is coherent.
REQ-018 On a read of 0x30000 SHALL pulse uart_rx_pop and latch uart_rx_data when uart_rx_empty=0, and SHALL return 0x00 without popping when empty.
REQ-019 A write to 0x30000 with a nonzero byte SHALL push the byte into the TX FIFO; a write of 0x00 SHALL be ignored.
REQ-020 The FIFO SHALL pop to uart_tx_data/uart_tx_valid (1-cycle valid pulse) whenever non-empty and uart_tx_full=0; push and pop in the same cycle SHALL leave the count unchanged.
REQ-021 io_buffer_full SHALL be 1 when count >= TX_DEPTH-1, giving one entry of slack for an in-flight write.
REQ-022 A push while count==TX_DEPTH SHALL be dropped and SHALL set a sticky internal overflow flag visible to the bench.
REQ-023 SHALL implement the FSM RUN -> DRAIN (on any write to 0x30004) -> SEND_NUL (FIFO empty) -> DONE (0x00 sent while uart_tx_full=0).
REQ-024 In DRAIN, SEND_NUL and DONE, further IO writes SHALL be ignored; RAM accesses SHALL still pass through.
REQ-025 program_finish SHALL be 1 only in DONE and SHALL hold until reset.

Reset
REQ-026 Reset SHALL set: FSM=RUN, FIFO empty, counter=0, snapshot=0, read source=RAM, overflow=0, cpu_din=0, uart_tx_valid=0, uart_rx_pop=0, program_finish=0, io_buffer_full=0.
REQ-027 Reset mid-drain or mid-read SHALL discard all pending TX bytes and read results without emitting a UART pulse.

Structure
REQ-028 IO addresses 0x30000/0x30004, the read-source encoding and the FSM state encoding SHALL live in the shared constants include.
REQ-029 The TX FIFO SHALL be one sub-module, io_tx_fifo (push/pop/count/full/empty); all else SHALL be flat.

Verification
REQ-030 Write 0x41 to 0x30000 with uart_tx_full=0 -> uart_tx_data=0x41 pulses within 2 cycles; a write of 0x00 -> no pulse.
REQ-031 Hold uart_tx_full=1 and write 7 bytes (TX_DEPTH=8) -> io_buffer_full=1 after the 7th; an 8th write is accepted, a 9th sets overflow.
REQ-032 Write 0x5A to RAM 0x00100 then read it -> cpu_din=0x5A the cycle after the read; ram_wr=0 throughout a 0x30000 access.
REQ-033 Read 0x30004..0x30007 across 4 cycles at counter=0x000000FF -> bytes 0xFF,0x00,0x00,0x00 with no carry tearing.
REQ-034 Queue 3 bytes then write 0x30004 -> 3 bytes, then 0x00, then program_finish=1; assert rst_in -> program_finish=0 and FIFO empty next cycle.
REQ-035 Drop rdy_in for 5 cycles mid-drain -> no uart_tx_valid, no change in counter or FSM, ram_wr=0.
